fetch_unit: RTL

Instruction fetch stage that sits between the code cache and decode. It owns the program counter and drives word-aligned fetch addresses. It tracks the cache's one-cycle registered read and its stall flag, and buffers returned instructions in a small queue. Decode consumes the queue through a valid/ready handshake. Branch and jump redirects from execute flush the stage.

---
 rtl/fetch_unit.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage between the code cache and decode. It owns the
// program counter and presents a word-aligned fetch address to the cache. The
// cache returns data one cycle later unless it raises its stall flag.
// Returned words are buffered in a small FIFO. Decode drains that FIFO through
// a valid/ready handshake. A redirect from execute flushes everything in
// flight and restarts fetching at the new PC.
//
// Handshake (decode side): the head entry transfers on a rising I_clk edge
// where O_valid && I_ready are both high. O_valid never depends on I_ready.
// O_instr/O_pc are stable while O_valid is high and the head has not been
// accepted.
//
// Parameters:
//   RESET_PC  PC loaded on reset (bits [1:0] ignored)
//   QDEPTH    instruction queue entries, 2 or 4
//
// Ports:
//   I_clk, I_rst        clock, synchronous active-high reset
//   O_imem_addr         fetch byte address to the cache (bits [1:0] = 0)
//   I_imem_data         instruction word, valid the cycle after the address
//   I_imem_stall        cache busy; the data this cycle is invalid
//   I_redirect          flush request from execute
//   I_redirect_pc       new PC (bits [1:0] forced to 0)
//   O_valid/O_instr/O_pc  queue head towards decode
//   I_ready             decode accepts the head this cycle
//
// Optional build macro FETCH_PERF_EN adds:
//   O_perf_stall_cnt    cycles in which an outstanding response stalled
//   O_perf_fetch_cnt    instructions pushed into the queue
// Both counters saturate and are cleared by I_rst.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        I_clk,
    input  logic        I_rst,
    output logic [31:0] O_imem_addr,
    input  logic [31:0] I_imem_data,
    input  logic        I_imem_stall,
    input  logic        I_redirect,
    input  logic [31:0] I_redirect_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0] O_perf_stall_cnt,
    output logic [31:0] O_perf_fetch_cnt,
`endif
    output logic        O_valid,
    output logic [31:0] O_instr,
    output logic [31:0] O_pc,
    input  logic        I_ready
);

    // Pointer width covers QDEPTH of 2 or 4. Both are powers of two, so the
    // pointers wrap naturally at QDEPTH.
    localparam int PW = (QDEPTH > 2) ? 2 : 1;
    // The count must be able to hold QDEPTH itself, plus the in-flight request
    // that is added in the issue check.
    localparam int CW = PW + 1;

    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_AL   = RESET_PC & PC_ALIGN_MASK;
    localparam logic [CW-1:0] QDEPTH_C    = CW'(QDEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          req_vld_q,  req_vld_d;
    logic [31:0]   req_pc_q,   req_pc_d;

    logic [31:0]   instr_mem_q [QDEPTH];
    logic [31:0]   pc_mem_q    [QDEPTH];
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0] count_q,    count_d;

    // The last values shown to decode. They keep O_instr/O_pc steady while
    // the queue is empty.
    logic [31:0]   last_instr_q;
    logic [31:0]   last_pc_q;

    // ------------------------------------------------------------------
    // Datapath control
    // ------------------------------------------------------------------
    logic          head_vld;
    logic          pop;
    logic          resp_stall;
    logic          push;
    logic          issue;
    logic [CW-1:0] count_after_pop;
    logic [CW-1:0] occupancy;

    assign head_vld   = (count_q != '0);
    assign pop        = head_vld && I_ready;

    // An outstanding request whose response the cache did not deliver.
    assign resp_stall = req_vld_q && I_imem_stall;

    // A redirect in the same cycle discards the arriving response.
    assign push       = req_vld_q && !I_imem_stall && !I_redirect;

    // Space check. It accounts for this cycle's pop and for the
    // request already in flight. If the in-flight request and the one
    // issued now both return, each still finds a free slot. That keeps
    // the queue from overflowing and allows one instruction per cycle
    // while decode keeps up.
    assign count_after_pop = count_q - CW'(pop);
    assign occupancy       = count_after_pop + CW'(req_vld_q);

    // No issue during a redirect. No issue while rolling back a stalled
    // response either: the rolled-back address has to be presented first.
    assign issue = !I_redirect && !resp_stall && (occupancy < QDEPTH_C);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_vld_d  = issue;
        req_pc_d   = req_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (I_redirect) begin
            fetch_pc_d = I_redirect_pc & PC_ALIGN_MASK;
            req_vld_d  = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (resp_stall) begin
                // The response was lost; present the same address again.
                fetch_pc_d = req_pc_q;
            end else if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end

            if (issue) begin
                req_pc_d = fetch_pc_q;
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_after_pop + CW'(push);
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            fetch_pc_q   <= RESET_PC_AL;
            req_vld_q    <= 1'b0;
            req_pc_q     <= RESET_PC_AL;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            req_vld_q    <= req_vld_d;
            req_pc_q     <= req_pc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_instr_q <= O_instr;
            last_pc_q    <= O_pc;
        end
    end

    // Queue storage needs no reset: an entry is read only after it has
    // been written, because count_q gates the read.
    always_ff @(posedge I_clk) begin
        if (!I_rst && push) begin
            instr_mem_q[wr_ptr_q] <= I_imem_data;
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign O_imem_addr = fetch_pc_q;
    assign O_valid     = head_vld;
    assign O_instr     = head_vld ? instr_mem_q[rd_ptr_q] : last_instr_q;
    assign O_pc        = head_vld ? pc_mem_q[rd_ptr_q]    : last_pc_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_fetch_q;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            perf_stall_q <= '0;
            perf_fetch_q <= '0;
        end else begin
            if (resp_stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (push && (perf_fetch_q != 32'hFFFF_FFFF)) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
        end
    end

    assign O_perf_stall_cnt = perf_stall_q;
    assign O_perf_fetch_cnt = perf_fetch_q;
`endif

endmodule
